// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl: sequences one 8x8 output-stationary matrix multiply.
// Clears the array, streams eight operand words from the A/B buffers, waits
// for compute_done, then unloads the accumulators one row per handshake.
module systolic_array_ctrl #(
  parameter int NUM_ROW       = 8,
  parameter int NUM_COL       = 8,
  parameter int IN_WORD_SIZE  = 8,
  parameter int OUT_WORD_SIZE = 24,
  parameter int TIMEOUT       = 64
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  output logic                                      busy,
  output logic                                      err,
  output logic                                      a_rd_en,
  output logic                                      b_rd_en,
  output logic [$clog2(NUM_ROW)-1:0]                a_rd_addr,
  output logic [$clog2(NUM_ROW)-1:0]                b_rd_addr,
  input  logic [NUM_ROW*IN_WORD_SIZE-1:0]           a_rd_data,
  input  logic [NUM_COL*IN_WORD_SIZE-1:0]           b_rd_data,
  output logic                                      arr_rst,
  output logic [NUM_ROW*IN_WORD_SIZE-1:0]           arr_left,
  output logic [NUM_COL*IN_WORD_SIZE-1:0]           arr_top,
  input  logic                                      arr_done,
  input  logic [NUM_ROW*NUM_COL*OUT_WORD_SIZE-1:0]  arr_vals,
  output logic                                      res_valid,
  input  logic                                      res_ready,
  output logic [NUM_COL*OUT_WORD_SIZE-1:0]          res_data,
  output logic [$clog2(NUM_ROW)-1:0]                res_row,
  output logic                                      res_last
);

  localparam int KW = $clog2(NUM_ROW);
  localparam int DW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [KW-1:0] K_MAX     = KW'(NUM_ROW - 1);
  localparam logic [DW-1:0] DRAIN_MAX = DW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, RESULT} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [KW-1:0] row_q, row_d;
  logic          err_q, err_d;
  logic          feed_q, feed_d;
  logic          busy_q, busy_d;
  logic          rd_en_q, rd_en_d;
  logic          arr_rst_q, arr_rst_d;
  logic          res_valid_q, res_valid_d;
  logic          res_last_q, res_last_d;

  // Next-state logic; outputs are derived from the next state so they come straight off flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    row_d   = row_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FEED;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      FEED: begin
        if (cnt_q == K_MAX) begin
          state_d = DRAIN;
          cnt_d   = '0;
          drain_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (arr_done) begin
          state_d = RESULT;
          row_d   = '0;
        end else if (drain_q == DRAIN_MAX) begin
          // Array never finished: abandon the job without producing results.
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      RESULT: begin
        if (res_valid_q && res_ready) begin
          if (row_q == K_MAX) begin
            state_d = IDLE;
            row_d   = '0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Operand data arrives one cycle after the read, so the mux window lags FEED by one.
    feed_d      = (state_q == FEED);
    busy_d      = (state_d != IDLE);
    rd_en_d     = (state_d == FEED);
    arr_rst_d   = (state_d == FEED) && (cnt_d == '0);
    res_valid_d = (state_d == RESULT);
    res_last_d  = (state_d == RESULT) && (row_d == K_MAX);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drain_q     <= '0;
      row_q       <= '0;
      err_q       <= 1'b0;
      feed_q      <= 1'b0;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      arr_rst_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      row_q       <= row_d;
      err_q       <= err_d;
      feed_q      <= feed_d;
      busy_q      <= busy_d;
      rd_en_q     <= rd_en_d;
      arr_rst_q   <= arr_rst_d;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
    end
  end

  assign busy      = busy_q;
  assign err       = err_q;
  assign a_rd_en   = rd_en_q;
  assign b_rd_en   = rd_en_q;
  assign a_rd_addr = cnt_q;
  assign b_rd_addr = cnt_q;
  // The array is cleared together with the controller and at the start of every job.
  assign arr_rst   = rst | arr_rst_q;
  assign arr_left  = feed_q ? a_rd_data : '0;
  assign arr_top   = feed_q ? b_rd_data : '0;
  assign res_valid = res_valid_q;
  assign res_row   = row_q;
  assign res_last  = res_last_q;

  // Row select: the array holds its accumulators, so a live mux is stable during stalls.
  generate
    for (genvar gi = 0; gi < NUM_COL; gi++) begin : g_res_col
      assign res_data[gi*OUT_WORD_SIZE +: OUT_WORD_SIZE] =
        arr_vals[(int'(row_q) * NUM_COL + gi) * OUT_WORD_SIZE +: OUT_WORD_SIZE];
    end
  endgenerate

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: behavioural operand buffers and array,
// golden matrix product, directed jobs with hand-derived timing.
module tb_systolic_array_ctrl;

  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst, start, busy, err;
  logic          a_rd_en, b_rd_en;
  logic [2:0]    a_rd_addr, b_rd_addr;
  logic [63:0]   a_rd_data, b_rd_data;
  logic          arr_rst, arr_done;
  logic [63:0]   arr_left, arr_top;
  logic [1535:0] arr_vals;
  logic          res_valid, res_ready, res_last;
  logic [191:0]  res_data;
  logic [2:0]    res_row;

  systolic_array_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .err(err),
    .a_rd_en(a_rd_en), .b_rd_en(b_rd_en), .a_rd_addr(a_rd_addr), .b_rd_addr(b_rd_addr),
    .a_rd_data(a_rd_data), .b_rd_data(b_rd_data), .arr_rst(arr_rst),
    .arr_left(arr_left), .arr_top(arr_top), .arr_done(arr_done), .arr_vals(arr_vals),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_row(res_row), .res_last(res_last)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Operand buffers with one-cycle read latency.
  logic [63:0] a_mem [8];
  logic [63:0] b_mem [8];
  int a_strobes = 0;
  int b_strobes = 0;
  always @(posedge clk) begin
    if (a_rd_en) begin
      a_rd_data <= a_mem[a_rd_addr];
      a_strobes <= a_strobes + 1;
    end
    if (b_rd_en) begin
      b_rd_data <= b_mem[b_rd_addr];
      b_strobes <= b_strobes + 1;
    end
  end

  // Behavioural array: accumulates outer products, raises done 23 cycles after clear.
  logic [23:0] acc [64];
  int          arr_cyc = 1000;
  logic        done_en;

  function automatic logic [23:0] mul8(input logic [7:0] a, input logic [7:0] b);
    logic [23:0] x, y;
    x = {16'd0, a};
    y = {16'd0, b};
    return x * y;
  endfunction

  always @(posedge clk) begin
    if (arr_rst) begin
      for (int i = 0; i < 64; i++) acc[i] <= '0;
      arr_cyc <= 0;
    end else begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          acc[r*8+c] <= acc[r*8+c] + mul8(arr_left[r*8 +: 8], arr_top[c*8 +: 8]);
      if (arr_cyc < 1000) arr_cyc <= arr_cyc + 1;
    end
  end

  always_comb begin
    arr_vals = '0;
    for (int i = 0; i < 64; i++) arr_vals[i*24 +: 24] = acc[i];
  end
  assign arr_done = done_en && (arr_cyc >= 23);

  // Golden operands and model.
  logic [7:0] am [8][8];
  logic [7:0] bm [8][8];

  function automatic logic [191:0] exp_row(input int r);
    logic [191:0] v;
    logic [23:0]  s;
    v = '0;
    for (int c = 0; c < 8; c++) begin
      s = '0;
      for (int k = 0; k < 8; k++) s = s + mul8(am[r][k], bm[k][c]);
      v[c*24 +: 24] = s;
    end
    return v;
  endfunction

  task automatic load_bufs();
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < 8; i++) begin
        a_mem[k][i*8 +: 8] = am[i][k];
        b_mem[k][i*8 +: 8] = bm[k][i];
      end
  endtask

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full job; timing checks assume res_ready held high.
  task automatic run_job(input string name, input bit timing, input bit rand_ready, input bit poke);
    int t0, n, rows, sa0, sb0;
    bit stalled, first_seen, fin, rdy;
    logic [191:0] prev_data;
    logic [2:0]   prev_row;
    rows = 0; stalled = 0; first_seen = 0; fin = 0;
    prev_data = '0; prev_row = '0;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc_cnt;
    sa0 = a_strobes;
    sb0 = b_strobes;
    @(negedge clk);
    start = 1'b0;
    while (!fin) begin
      n = cyc_cnt - t0;
      if (n == 1) begin
        chk({name, " err_clr"}, err, 0);
        chk({name, " busy"}, busy, 1);
        if (timing) begin
          chk({name, " arr_rst_t1"}, arr_rst, 1);
          chk({name, " addr_t1"}, a_rd_addr, 0);
        end
      end
      if (timing && n == 2) chk({name, " left_t2"}, arr_left, a_mem[0]);
      if (timing && n == 8) chk({name, " addr_t8"}, b_rd_addr, 7);
      if (timing && n == 9) chk({name, " top_t9"}, arr_top, b_mem[7]);
      if (timing && n == 10) chk({name, " left_zero"}, arr_left, 0);
      if (stalled) begin
        chk({name, " stall_data"}, res_data, prev_data);
        chk({name, " stall_row"}, res_row, prev_row);
      end
      if (res_valid && !first_seen) begin
        first_seen = 1;
        if (timing) chk({name, " first_valid"}, n, 26);
      end
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      res_ready = rdy;
      stalled   = res_valid && !rdy;
      prev_data = res_data;
      prev_row  = res_row;
      if (res_valid && rdy) begin
        chk({name, " row"}, res_row, rows);
        chk({name, " data"}, res_data, exp_row(rows));
        chk({name, " last"}, res_last, (rows == 7));
        rows++;
      end
      start = poke && (n == 4 || n == 15 || n == 27);
      if (!busy && n > 1) begin
        fin = 1;
        if (timing) chk({name, " idle_at"}, n, 34);
      end else if (n > 400) begin
        chk({name, " job_bound"}, n, 0);
        fin = 1;
      end
      if (!fin) @(negedge clk);
    end
    start = 1'b0;
    res_ready = 1'b0;
    chk({name, " rows"}, rows, 8);
    chk({name, " a_strobes"}, a_strobes - sa0, 8);
    chk({name, " b_strobes"}, b_strobes - sb0, 8);
    $display("job %s: %0d rows, %0d cycles", name, rows, n);
  endtask

  initial begin
    int t0, n;
    bit saw_valid;
    rst = 1'b1; start = 1'b0; res_ready = 1'b0; done_en = 1'b1;
    for (int k = 0; k < 8; k++) begin a_mem[k] = '0; b_mem[k] = '0; end
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst err", err, 0);
    chk("rst rd_en", {a_rd_en, b_rd_en}, 0);
    chk("rst addr", {a_rd_addr, b_rd_addr}, 0);
    chk("rst arr_rst", arr_rst, 1);
    chk("rst operands", {arr_left, arr_top}, 0);
    chk("rst res", {res_valid, res_row, res_last}, 0);
    rst = 1'b0;
    @(negedge clk);
    $display("reset: outputs checked");

    // Identity A, B[k][j] = 8k+j: row r returns B row r.
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        am[i][j] = (i == j) ? 8'd1 : 8'd0;
        bm[i][j] = 8'(8*i + j);
      end
    load_bufs();
    chk("ident row2 model", exp_row(2),
        {24'd23, 24'd22, 24'd21, 24'd20, 24'd19, 24'd18, 24'd17, 24'd16});
    run_job("identity", 1, 0, 0);

    // All ones -> 8 everywhere.
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin am[i][j] = 8'd1; bm[i][j] = 8'd1; end
    load_bufs();
    chk("ones model", exp_row(0), {8{24'd8}});
    run_job("ones", 1, 0, 0);

    // All 255 -> 520200 everywhere.
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin am[i][j] = 8'hFF; bm[i][j] = 8'hFF; end
    load_bufs();
    chk("max model", exp_row(7), {8{24'h07F008}});
    run_job("max", 1, 0, 0);

    // Random operands, back-pressure, and start pulses in every busy state.
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) begin
          am[i][j] = 8'($urandom_range(0, 255));
          bm[i][j] = 8'($urandom_range(0, 255));
        end
      load_bufs();
      run_job($sformatf("random%0d", t), 0, 1, (t != 1));
    end
    run_job("after_poke", 1, 0, 0);

    // Reset at cnt=4 of FEED discards the job.
    @(negedge clk);
    start = 1'b1;
    t0 = cyc_cnt;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst cnt4", a_rd_addr, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", busy, 0);
    chk("midrst valid", res_valid, 0);
    chk("midrst rd_en", a_rd_en, 0);
    chk("midrst arr_rst", arr_rst, 1);
    rst = 1'b0;
    $display("midrst: job aborted at cycle %0d", cyc_cnt - t0);
    run_job("post_rst", 1, 0, 0);

    // arr_done stuck low: timeout sets err, no results.
    done_en = 1'b0;
    saw_valid = 0;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc_cnt;
    @(negedge clk);
    start = 1'b0;
    res_ready = 1'b1;
    n = 1;
    while (busy && n < 200) begin
      if (res_valid) saw_valid = 1;
      @(negedge clk);
      n = cyc_cnt - t0;
    end
    chk("timeout idle_at", n, 9 + TIMEOUT);
    chk("timeout err", err, 1);
    chk("timeout no_valid", saw_valid, 0);
    repeat (5) @(negedge clk);
    chk("timeout err_hold", err, 1);
    res_ready = 1'b0;
    $display("timeout: idle after %0d cycles", n);
    done_en = 1'b1;
    run_job("after_timeout", 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
